mux8_serial_sequencer: RTL and testbench



---
 rtl/mux8_pkg.sv | 28 ++
 rtl/mux8_ser_outreg.sv | 36 +++
 rtl/mux8_serial_sequencer.sv | 123 ++++++++++++
 tb/tb_mux8_serial_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux8_pkg.sv
// Shared types and helpers for the 8:1 mux serial sequencer.
package mux8_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic s0;
        logic s1;
        logic s2;
    } sel_t;

    // s0 carries the index MSB and s2 the LSB, matching the mux pinout.
    function automatic sel_t split_index(input logic [SEL_W-1:0] index);
        sel_t sel;
        sel.s0 = index[2];
        sel.s1 = index[1];
        sel.s2 = index[0];
        return sel;
    endfunction

endpackage

// File: rtl/mux8_ser_outreg.sv
// Registered serial output stage: one data bit plus first/last framing with valid/ready.
module mux8_ser_outreg (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic load_data,
    input  logic load_first,
    input  logic load_last,
    input  logic ready,
    output logic advance,
    output logic valid,
    output logic data,
    output logic first,
    output logic last
);

    assign advance = !valid || ready;

    // A new sample replaces the register; otherwise a consumed bit clears valid while payload holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= 1'b0;
            first <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            first <= load_first;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux8_serial_sequencer.sv
// Upstream controller for the 8:1 mux: holds a word, walks the selects and serialises mux_y.
module mux8_serial_sequencer
    import mux8_pkg::*;
#(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] mux_d,
    output logic              mux_s0,
    output logic              mux_s1,
    output logic              mux_s2,
    input  logic              mux_y,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_data,
    output logic              ser_first,
    output logic              ser_last
);

    localparam logic [SEL_W-1:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [SEL_W-1:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [3:0]       GAP_LOAD  = 4'(GAP_CYCLES);
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

    state_t             state;
    state_t             state_next;
    logic [SEL_W-1:0]   index;
    logic [SEL_W-1:0]   index_next;
    logic [3:0]         gap_cnt;
    logic [3:0]         gap_cnt_next;
    logic [DATA_W-1:0]  word_q;
    logic [DATA_W-1:0]  word_next;
    logic               load;
    logic               advance;
    sel_t               sel;

    assign in_ready = (state == IDLE);
    assign mux_d    = word_q;
    assign sel      = split_index(index);
    assign mux_s0   = sel.s0;
    assign mux_s1   = sel.s1;
    assign mux_s2   = sel.s2;

    // State, select index, gap counter and held word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            index   <= '0;
            gap_cnt <= '0;
            word_q  <= '0;
        end else begin
            state   <= state_next;
            index   <= index_next;
            gap_cnt <= gap_cnt_next;
            word_q  <= word_next;
        end
    end

    // Next-state logic: accept in IDLE, sample one bit per advance in SHIFT, count down in GAP.
    always_comb begin
        state_next   = state;
        index_next   = index;
        gap_cnt_next = gap_cnt;
        word_next    = word_q;
        load         = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    word_next  = in_data;
                    index_next = START_IDX;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (advance) begin
                    load = 1'b1;
                    if (index == END_IDX) begin
                        if (HAS_GAP) begin
                            state_next   = GAP;
                            gap_cnt_next = GAP_LOAD;
                        end else begin
                            state_next = IDLE;
                        end
                    end else if (MSB_FIRST) begin
                        index_next = index - 3'd1;
                    end else begin
                        index_next = index + 3'd1;
                    end
                end
            end
            GAP: begin
                gap_cnt_next = gap_cnt - 4'd1;
                if (gap_cnt <= 4'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    mux8_ser_outreg u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (mux_y),
        .load_first (index == START_IDX),
        .load_last  (index == END_IDX),
        .ready      (ser_ready),
        .advance    (advance),
        .valid      (ser_valid),
        .data       (ser_data),
        .first      (ser_first),
        .last       (ser_last)
    );

endmodule

// File: tb/tb_mux8_serial_sequencer.sv
// Directed bench: an LSB-first/no-gap instance and an MSB-first/gap-2 instance, each with a mux model.
module tb_mux8_serial_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic [7:0] mux_d     [2];
    logic       s0        [2];
    logic       s1        [2];
    logic       s2        [2];
    logic       mux_y     [2];
    logic       ser_valid [2];
    logic       ser_ready [2];
    logic       ser_data  [2];
    logic       ser_first [2];
    logic       ser_last  [2];

    int total;
    int bad;

    // Behavioural 8:1 mux: y = d[{s0,s1,s2}] in the same cycle.
    assign mux_y[0] = mux_d[0][{s0[0], s1[0], s2[0]}];
    assign mux_y[1] = mux_d[1][{s0[1], s1[1], s2[1]}];

    mux8_serial_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .mux_d(mux_d[0]), .mux_s0(s0[0]), .mux_s1(s1[0]), .mux_s2(s2[0]), .mux_y(mux_y[0]),
        .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]), .ser_data(ser_data[0]),
        .ser_first(ser_first[0]), .ser_last(ser_last[0])
    );

    mux8_serial_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_msb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .mux_d(mux_d[1]), .mux_s0(s0[1]), .mux_s1(s1[1]), .mux_s2(s2[1]), .mux_y(mux_y[1]),
        .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]), .ser_data(ser_data[1]),
        .ser_first(ser_first[1]), .ser_last(ser_last[1])
    );

    // 10-unit clock; all driving and sampling happens on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Bit index sampled for the j-th bit of a word on instance k.
    function automatic int orderIdx(input int k, input int j);
        return (k == 1) ? (7 - j) : j;
    endfunction

    function automatic int selOf(input int k);
        return {29'd0, s0[k], s1[k], s2[k]};
    endfunction

    // Send one word on instance k and check its stream; optional stall, mid-word reset and in_data toggling.
    task automatic applyStimulus(input int k, input logic [7:0] word, input int stall_bit,
                                 input int stall_len, input int abort_bit, input bit toggle);
        int guard;
        int j;
        int stalls;
        int cyc;
        bit aborted;
        @(negedge clk);
        ser_ready[k] = 1'b1;
        in_valid[k]  = 1'b1;
        in_data[k]   = word;
        guard = 0;
        while (!in_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_ready", in_ready[k], 1);
        @(negedge clk);
        in_valid[k] = 1'b0;
        checkOutput("ready_low_in_shift", in_ready[k], 0);
        checkOutput("start_sel", selOf(k), orderIdx(k, 0));
        checkOutput("valid_before_first", ser_valid[k], 0);
        checkOutput("mux_d_loaded", mux_d[k], word);
        j = 0;
        stalls = 0;
        cyc = 0;
        aborted = 1'b0;
        while (j < 8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (toggle) in_data[k] = ~in_data[k];
            checkOutput("mux_d_hold", mux_d[k], word);
            if (!ser_valid[k]) begin
                checkOutput("valid_no_bubble", 0, 1);
            end else begin
                if (j == 0) checkOutput("first_latency", cyc, 1);
                checkOutput("ser_data", ser_data[k], word[orderIdx(k, j)]);
                checkOutput("ser_first", ser_first[k], (j == 0) ? 1 : 0);
                checkOutput("ser_last", ser_last[k], (j == 7) ? 1 : 0);
                checkOutput("sel_step", selOf(k), orderIdx(k, (j < 7) ? j + 1 : 7));
                if (abort_bit == j + 1) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("rst_valid", ser_valid[k], 0);
                    checkOutput("rst_data", ser_data[k], 0);
                    checkOutput("rst_first", ser_first[k], 0);
                    checkOutput("rst_last", ser_last[k], 0);
                    checkOutput("rst_mux_d", mux_d[k], 0);
                    checkOutput("rst_sel", selOf(k), 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    ser_ready[k] = 1'b1;
                    @(negedge clk);
                    checkOutput("ready_after_rst", in_ready[k], 1);
                    checkOutput("valid_after_rst", ser_valid[k], 0);
                    aborted = 1'b1;
                    break;
                end
                if (j + 1 == stall_bit && stalls < stall_len) begin
                    ser_ready[k] = 1'b0;
                    stalls++;
                end else begin
                    ser_ready[k] = 1'b1;
                    j++;
                end
            end
        end
        if (!aborted) begin
            checkOutput("bit_count", j, 8);
            checkOutput("stall_count", stalls, stall_len);
            @(negedge clk);
            checkOutput("valid_drop", ser_valid[k], 0);
        end
    endtask

    // Two words back to back with in_valid held high on the gap-2 instance.
    task automatic applyBackToBack();
        int cyc;
        int acc1;
        int acc2;
        int low_cnt;
        int nbits;
        logic [15:0] bits;
        logic [15:0] firsts;
        logic [15:0] lasts;
        bits = '0;
        firsts = '0;
        lasts = '0;
        acc1 = -1;
        acc2 = -1;
        cyc = 0;
        low_cnt = 0;
        nbits = 0;
        @(negedge clk);
        ser_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_data[1]   = 8'hFF;
        while (cyc < 60 && !(acc2 >= 0 && cyc >= acc2 + 10)) begin
            if (ser_valid[1]) begin
                if (nbits < 16) begin
                    bits[15 - nbits]   = ser_data[1];
                    firsts[15 - nbits] = ser_first[1];
                    lasts[15 - nbits]  = ser_last[1];
                end
                nbits++;
            end
            if (in_ready[1] && in_valid[1]) begin
                if (acc1 < 0) acc1 = cyc;
                else acc2 = cyc;
            end else if (!in_ready[1] && acc1 >= 0 && acc2 < 0) begin
                low_cnt++;
            end
            @(negedge clk);
            cyc++;
            if (acc2 >= 0) in_valid[1] = 1'b0;
            else if (acc1 >= 0) in_data[1] = 8'h00;
        end
        in_valid[1] = 1'b0;
        checkOutput("b2b_second_accepted", (acc2 >= 0) ? 1 : 0, 1);
        checkOutput("b2b_period", acc2 - acc1, 11);
        checkOutput("b2b_ready_low", low_cnt, 10);
        checkOutput("b2b_nbits", nbits, 16);
        checkOutput("b2b_bits", bits, 16'hFF00);
        checkOutput("b2b_first", firsts, 16'h8080);
        checkOutput("b2b_last", lasts, 16'h0101);
        @(negedge clk);
        checkOutput("b2b_valid_drop", ser_valid[1], 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = 8'h00;
            ser_ready[k] = 1'b1;
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_valid", ser_valid[k], 0);
            checkOutput("reset_data", ser_data[k], 0);
            checkOutput("reset_first", ser_first[k], 0);
            checkOutput("reset_last", ser_last[k], 0);
            checkOutput("reset_mux_d", mux_d[k], 0);
            checkOutput("reset_sel", selOf(k), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset_lsb", in_ready[0], 1);
        checkOutput("ready_after_reset_msb", in_ready[1], 1);

        $display("[TB] basic LSB-first 8'hA5");
        applyStimulus(0, 8'hA5, 0, 0, 0, 1'b0);
        $display("[TB] MSB-first 8'h81");
        applyStimulus(1, 8'h81, 0, 0, 0, 1'b0);
        $display("[TB] backpressure on bit 3 of 8'h6B");
        applyStimulus(0, 8'h6B, 3, 3, 0, 1'b0);
        $display("[TB] back-to-back 8'hFF then 8'h00 with gap 2");
        applyBackToBack();
        $display("[TB] reset after bit 4 of 8'h3C, then 8'hC3");
        applyStimulus(0, 8'h3C, 0, 0, 4, 1'b0);
        applyStimulus(0, 8'hC3, 0, 0, 0, 1'b0);
        $display("[TB] in_data toggling while 8'h5A shifts");
        applyStimulus(0, 8'h5A, 0, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
